// File: rtl/lotr_pkg.sv
// Shared types and constants for the VGA text-mode character writer.
// Provides FSM state enum, command record, address and glyph helpers.
package lotr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR0,
        WR1,
        CLR
    } t_vga_chr_state;

    localparam int VGA_WORDS_PER_LINE = 80;
    localparam int VGA_BITMAP_WORDS   = 9600;

    typedef struct packed {
        logic [7:0] ascii;
        logic [6:0] col;
        logic [5:0] row;
        logic       invert;
    } t_vga_chr_cmd;

    // Word address of half `half` of the character cell at (col,row).
    // A word spans 4 pixel lines, so a cell covers word-lines 2r and 2r+1.
    function automatic logic [13:0] vga_chr_addr(
        input logic [5:0] row,
        input logic [6:0] col,
        input logic       half
    );
        logic [13:0] wline;
        wline = {7'd0, row, half};
        return wline * 14'(VGA_WORDS_PER_LINE) + {7'd0, col};
    endfunction

    // Built-in pattern font: row i of glyph c is c ^ byte i of a fixed key.
    function automatic logic [63:0] vga_font_glyph(input logic [7:0] code);
        return {8{code}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

endpackage

// File: rtl/vga_font_rom.sv
// 256 x 64-bit synchronous glyph ROM, one-cycle read latency.
// Ports: clk/rst_n, rd_en + rd_addr (glyph code) in, rd_data (8 rows) out.
module vga_font_rom
    import lotr_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_en,
    input  logic [7:0]  rd_addr,
    output logic [63:0] rd_data
);

    logic [63:0] data_q;
    logic [63:0] data_d;

    // Output holds between reads so both halves stay available to WR0/WR1.
    always_comb begin
        data_d = data_q;
        if (rd_en) begin
            data_d = vga_font_glyph(rd_addr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign rd_data = data_q;

endmodule

// File: rtl/vga_char_writer.sv
// Text-mode front end: turns (ascii,col,row) commands into two 32-bit word
// writes of the 8x8 glyph, and fills the bitmap on ClearReq.
// Ports: QClk/Reset_N; Cmd* valid/ready command input; ClearReq/ClearVal;
// WrReq/WrGnt/WrAddr/WrData memory write port; Busy and sticky DropErr status.
module vga_char_writer
    import lotr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TEXT_COLS  = 80,
    parameter int TEXT_ROWS  = 60
) (
    input  logic        QClk,
    input  logic        Reset_N,
    input  logic        CmdValid,
    output logic        CmdReady,
    input  logic [7:0]  CmdAscii,
    input  logic [6:0]  CmdCol,
    input  logic [5:0]  CmdRow,
    input  logic        CmdInvert,
    input  logic        ClearReq,
    input  logic        ClearVal,
    output logic        WrReq,
    input  logic        WrGnt,
    output logic [13:0] WrAddr,
    output logic [31:0] WrData,
    output logic        Busy,
    output logic        DropErr
);

    localparam int PW = $clog2(FIFO_DEPTH);

    t_vga_chr_state state_q, state_d;
    t_vga_chr_cmd   fifo_q [FIFO_DEPTH];
    t_vga_chr_cmd   fifo_d [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic [6:0]     cur_col_q, cur_col_d;
    logic [5:0]     cur_row_q, cur_row_d;
    logic           cur_inv_q, cur_inv_d;
    logic           clr_pend_q, clr_pend_d;
    logic           clr_val_q, clr_val_d;
    logic           drop_err_q, drop_err_d;
    logic           wr_req_q, wr_req_d;
    logic [13:0]    wr_addr_q, wr_addr_d;
    logic [31:0]    wr_data_q, wr_data_d;

    t_vga_chr_cmd   head;
    logic           push, pop, head_ok;
    logic [63:0]    glyph;
    logic [31:0]    inv_mask;

    assign CmdReady = (count_q != (PW+1)'(FIFO_DEPTH));
    assign push     = CmdValid && CmdReady;
    assign head     = fifo_q[rd_ptr_q];
    // A pending clear blocks the pop so queued characters land after it.
    assign pop      = (state_q == IDLE) && !clr_pend_q && (count_q != '0);
    assign head_ok  = (32'(head.col) < TEXT_COLS) &&
                      (32'(head.row) < TEXT_ROWS);
    assign inv_mask = {32{cur_inv_q}};

    vga_font_rom u_rom (
        .clk     (QClk),
        .rst_n   (Reset_N),
        .rd_en   (pop && head_ok),
        .rd_addr (head.ascii),
        .rd_data (glyph)
    );

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        cur_col_d  = cur_col_q;
        cur_row_d  = cur_row_q;
        cur_inv_d  = cur_inv_q;
        clr_pend_d = clr_pend_q;
        clr_val_d  = clr_val_q;
        drop_err_d = drop_err_q;
        wr_req_d   = wr_req_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (push) begin
            fifo_d[wr_ptr_q] = '{ascii: CmdAscii, col: CmdCol,
                                 row: CmdRow, invert: CmdInvert};
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (clr_pend_q) begin
                    state_d    = CLR;
                    clr_pend_d = 1'b0;
                    wr_req_d   = 1'b1;
                    wr_addr_d  = '0;
                    wr_data_d  = {32{clr_val_q}};
                end else if (pop) begin
                    if (head_ok) begin
                        state_d   = FETCH;
                        cur_col_d = head.col;
                        cur_row_d = head.row;
                        cur_inv_d = head.invert;
                    end else begin
                        drop_err_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_d   = WR0;
                wr_req_d  = 1'b1;
                wr_addr_d = vga_chr_addr(cur_row_q, cur_col_q, 1'b0);
                wr_data_d = glyph[31:0] ^ inv_mask;
            end
            WR0: begin
                if (WrGnt) begin
                    state_d   = WR1;
                    wr_addr_d = vga_chr_addr(cur_row_q, cur_col_q, 1'b1);
                    wr_data_d = glyph[63:32] ^ inv_mask;
                end
            end
            WR1: begin
                if (WrGnt) begin
                    state_d  = IDLE;
                    wr_req_d = 1'b0;
                end
            end
            CLR: begin
                if (WrGnt) begin
                    if (wr_addr_q == 14'(VGA_BITMAP_WORDS - 1)) begin
                        state_d  = IDLE;
                        wr_req_d = 1'b0;
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                wr_req_d = 1'b0;
            end
        endcase

        // A new clear during a fill restarts it rather than queueing another.
        if (ClearReq) begin
            clr_val_d  = ClearVal;
            drop_err_d = 1'b0;
            if (state_q == CLR) begin
                state_d   = CLR;
                wr_req_d  = 1'b1;
                wr_addr_d = '0;
                wr_data_d = {32{ClearVal}};
            end else begin
                clr_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge QClk or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            cur_inv_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            clr_val_q  <= 1'b0;
            drop_err_q <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
            cur_inv_q  <= cur_inv_d;
            clr_pend_q <= clr_pend_d;
            clr_val_q  <= clr_val_d;
            drop_err_q <= drop_err_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign WrReq   = wr_req_q;
    assign WrAddr  = wr_addr_q;
    assign WrData  = wr_data_q;
    assign DropErr = drop_err_q;
    assign Busy    = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_vga_char_writer.sv
// Self-checking bench for vga_char_writer.
// Directed vector table plus hand sequences for stall, FIFO, clear and reset.
module tb_vga_char_writer;

    logic        QClk = 1'b0;
    logic        Reset_N;
    logic        CmdValid;
    logic        CmdReady;
    logic [7:0]  CmdAscii;
    logic [6:0]  CmdCol;
    logic [5:0]  CmdRow;
    logic        CmdInvert;
    logic        ClearReq;
    logic        ClearVal;
    logic        WrReq;
    logic        WrGnt;
    logic [13:0] WrAddr;
    logic [31:0] WrData;
    logic        Busy;
    logic        DropErr;

    vga_char_writer dut (
        .QClk      (QClk),
        .Reset_N   (Reset_N),
        .CmdValid  (CmdValid),
        .CmdReady  (CmdReady),
        .CmdAscii  (CmdAscii),
        .CmdCol    (CmdCol),
        .CmdRow    (CmdRow),
        .CmdInvert (CmdInvert),
        .ClearReq  (ClearReq),
        .ClearVal  (ClearVal),
        .WrReq     (WrReq),
        .WrGnt     (WrGnt),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .Busy      (Busy),
        .DropErr   (DropErr)
    );

    always #5 QClk = ~QClk;

    typedef struct {
        int          cyc;
        logic [13:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic [7:0]  a;
        logic [6:0]  c;
        logic [5:0]  r;
        logic        inv;
        logic        drop;
        logic [13:0] a0;
        logic [31:0] d0;
        logic [13:0] a1;
        logic [31:0] d1;
    } vec_t;

    wr_t  wq[$];
    wr_t  rec;
    int   cyc = 0;
    int   push_cyc;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge QClk) cyc <= cyc + 1;

    // Every accepted write (WrReq && WrGnt) is logged with its cycle.
    always @(negedge QClk) begin
        if (Reset_N && WrReq && WrGnt) begin
            rec.cyc = cyc;
            rec.a   = WrAddr;
            rec.d   = WrData;
            wq.push_back(rec);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [6:0] c,
                            input logic [5:0] r, input logic inv);
        @(posedge QClk); #1;
        CmdValid  = 1'b1;
        CmdAscii  = a;
        CmdCol    = c;
        CmdRow    = r;
        CmdInvert = inv;
        push_cyc  = cyc;
        @(posedge QClk); #1;
        CmdValid  = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            @(negedge QClk);
            if (!Busy) break;
        end
        chk(nm, Busy, 0);
    endtask

    task automatic wait_req(input int maxc, input string nm);
        for (int i = 0; i < maxc; i++) begin
            @(negedge QClk);
            if (WrReq) break;
        end
        chk(nm, WrReq, 1);
    endtask

    vec_t vt[5];
    logic [13:0] fa0[5];
    logic [13:0] fa1[5];
    logic [31:0] fd0[5];
    logic [31:0] fd1[5];

    initial begin
        int bad;

        vt[0] = '{8'h41, 7'd0,  6'd0,  1'b0, 1'b0,
                  14'd0,    32'hC8EA8CAE, 14'd80,   32'h40620426};
        vt[1] = '{8'h00, 7'd79, 6'd59, 1'b1, 1'b0,
                  14'd9519, 32'h76543210, 14'd9599, 32'hFEDCBA98};
        vt[2] = '{8'h03, 7'd3,  6'd3,  1'b0, 1'b0,
                  14'd483,  32'h8AA8CEEC, 14'd563,  32'h02204664};
        vt[3] = '{8'h41, 7'd80, 6'd0,  1'b0, 1'b1,
                  14'd0, 32'h0, 14'd0, 32'h0};
        vt[4] = '{8'h41, 7'd0,  6'd60, 1'b0, 1'b1,
                  14'd0, 32'h0, 14'd0, 32'h0};

        fa0 = '{14'd161, 14'd322, 14'd483, 14'd644, 14'd805};
        fa1 = '{14'd241, 14'd402, 14'd563, 14'd724, 14'd885};
        fd0 = '{32'h88AACCEE, 32'h8BA9CFED, 32'h8AA8CEEC,
                32'h8DAFC9EB, 32'h8CAEC8EA};
        fd1 = '{32'h00224466, 32'h03214765, 32'h02204664,
                32'h05274163, 32'h04264062};

        Reset_N   = 1'b0;
        CmdValid  = 1'b0;
        CmdAscii  = '0;
        CmdCol    = '0;
        CmdRow    = '0;
        CmdInvert = 1'b0;
        ClearReq  = 1'b0;
        ClearVal  = 1'b0;
        WrGnt     = 1'b1;

        repeat (2) @(negedge QClk);
        chk("rst_wrreq",  WrReq,    0);
        chk("rst_wraddr", WrAddr,   0);
        chk("rst_wrdata", WrData,   0);
        chk("rst_busy",   Busy,     0);
        chk("rst_drop",   DropErr,  0);
        chk("rst_ready",  CmdReady, 1);
        @(posedge QClk); #1;
        Reset_N = 1'b1;

        // Directed vector table
        for (int i = 0; i < 5; i++) begin
            wq.delete();
            push_cmd(vt[i].a, vt[i].c, vt[i].r, vt[i].inv);
            wait_idle(20, $sformatf("v%0d_idle", i));
            chk($sformatf("v%0d_drop", i), DropErr, vt[i].drop);
            if (vt[i].drop) begin
                chk($sformatf("v%0d_nwr", i), wq.size(), 0);
            end else begin
                chk($sformatf("v%0d_nwr", i), wq.size(), 2);
                if (wq.size() == 2) begin
                    chk($sformatf("v%0d_a0", i), wq[0].a, vt[i].a0);
                    chk($sformatf("v%0d_d0", i), wq[0].d, vt[i].d0);
                    chk($sformatf("v%0d_a1", i), wq[1].a, vt[i].a1);
                    chk($sformatf("v%0d_d1", i), wq[1].d, vt[i].d1);
                    chk($sformatf("v%0d_consec", i),
                        wq[1].cyc - wq[0].cyc, 1);
                    chk($sformatf("v%0d_lat", i),
                        wq[0].cyc - push_cyc, 3);
                end
            end
        end

        // ClearReq clears DropErr, then a full fill with zeros
        wq.delete();
        @(posedge QClk); #1;
        ClearReq = 1'b1;
        ClearVal = 1'b0;
        @(posedge QClk); #1;
        ClearReq = 1'b0;
        @(negedge QClk);
        chk("clr0_drop", DropErr, 0);
        @(negedge QClk);
        chk("clr0_busy", Busy, 1);
        wait_idle(9700, "clr0_idle");
        chk("clr0_req", WrReq, 0);
        chk("clr0_nwr", wq.size(), 9600);
        bad = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].a !== 14'(i) || wq[i].d !== 32'h0) bad++;
        end
        chk("clr0_seq", bad, 0);

        // Grant withheld for 5 cycles in WR0
        @(posedge QClk); #1;
        WrGnt = 1'b0;
        wq.delete();
        push_cmd(8'h41, 7'd0, 6'd0, 1'b0);
        wait_req(10, "stall_req");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_req%0d", k),  WrReq,  1);
            chk($sformatf("stall_addr%0d", k), WrAddr, 0);
            chk($sformatf("stall_data%0d", k), WrData, 32'hC8EA8CAE);
            @(negedge QClk);
        end
        @(posedge QClk); #1;
        WrGnt = 1'b1;
        wait_idle(20, "stall_idle");
        chk("stall_nwr", wq.size(), 2);
        if (wq.size() == 2) begin
            chk("stall_a0", wq[0].a, 0);
            chk("stall_d0", wq[0].d, 32'hC8EA8CAE);
            chk("stall_a1", wq[1].a, 80);
            chk("stall_d1", wq[1].d, 32'h40620426);
        end

        // Six back-to-back pushes against a stalled port
        @(posedge QClk); #1;
        WrGnt = 1'b0;
        wq.delete();
        for (int k = 1; k <= 6; k++) begin
            CmdValid  = 1'b1;
            CmdAscii  = 8'(k);
            CmdCol    = 7'(k);
            CmdRow    = 6'(k);
            CmdInvert = 1'b0;
            chk($sformatf("fifo_rdy%0d", k), CmdReady, (k <= 5));
            @(posedge QClk); #1;
        end
        CmdValid = 1'b0;
        @(negedge QClk);
        chk("fifo_full", CmdReady, 0);
        @(posedge QClk); #1;
        WrGnt = 1'b1;
        wait_idle(100, "fifo_idle");
        chk("fifo_nwr", wq.size(), 10);
        if (wq.size() == 10) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("fifo%0d_a0", k), wq[2*k].a,   fa0[k]);
                chk($sformatf("fifo%0d_d0", k), wq[2*k].d,   fd0[k]);
                chk($sformatf("fifo%0d_a1", k), wq[2*k+1].a, fa1[k]);
                chk($sformatf("fifo%0d_d1", k), wq[2*k+1].d, fd1[k]);
            end
        end

        // ClearReq during WR1, then reset mid-fill
        wq.delete();
        push_cmd(8'h41, 7'd0, 6'd0, 1'b0);
        wait_req(10, "clr1_wr0");
        @(posedge QClk); #1;
        ClearReq = 1'b1;
        ClearVal = 1'b1;
        @(posedge QClk); #1;
        ClearReq = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge QClk);
            if (WrReq && WrAddr == 14'd5000) break;
        end
        chk("clr1_at5000", WrAddr, 5000);
        Reset_N = 1'b0;
        #1;
        chk("rst2_wrreq",  WrReq,    0);
        chk("rst2_busy",   Busy,     0);
        chk("rst2_wraddr", WrAddr,   0);
        chk("rst2_wrdata", WrData,   0);
        chk("rst2_ready",  CmdReady, 1);
        chk("clr1_nwr", (wq.size() >= 5002), 1);
        if (wq.size() >= 5002) begin
            chk("clr1_ca0", wq[0].a, 0);
            chk("clr1_cd0", wq[0].d, 32'hC8EA8CAE);
            chk("clr1_ca1", wq[1].a, 80);
            chk("clr1_cd1", wq[1].d, 32'h40620426);
            bad = 0;
            for (int i = 2; i < 5002; i++) begin
                if (wq[i].a !== 14'(i - 2) || wq[i].d !== 32'hFFFFFFFF) bad++;
            end
            chk("clr1_seq", bad, 0);
        end
        @(posedge QClk); #1;
        Reset_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge QClk);
            if (WrReq || Busy) bad++;
        end
        chk("rst2_noresume", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
